fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end between the ibus and the decode stage. Generates sequential
//  PCs, keeps up to MAX_OUT requests in flight and buffers returned words with their PCs in a DEPTH-entry

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, bounded in-flight ibus requests, DEPTH-entry
// instruction FIFO and redirect handling. Optional same-cycle response bypass: FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     ireq_valid,
  output logic [31:0]              ireq_addr,
  input  logic                     iresp_addr_ok,
  input  logic                     iresp_data_ok,
  input  logic [31:0]              iresp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(MAX_OUT) + 1;
  localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0]   r_pc;
  logic          r_req_valid;
  logic [31:0]   r_req_addr;
  logic          r_stale;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [QW-1:0] r_ifq_wp;
  logic [QW-1:0] r_ifq_rp;
  logic [31:0]   r_ifq [MAX_OUT];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [31:0]   r_fifo_pc [DEPTH];

  logic          w_accept;
  logic          w_resp;
  logic          w_drop;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_pc_next;
  logic [IW-1:0] w_inflight_next;
  logic [IW-1:0] w_discard_next;
  logic [CW-1:0] w_count_next;
  logic          w_credit;
  logic          w_hold;

  function automatic logic [QW-1:0] ifq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_accept      = r_req_valid & iresp_addr_ok;
  assign w_resp        = iresp_data_ok & (r_inflight != '0);
  assign w_drop        = w_resp & (redirect_valid | (r_discard != '0));
  assign w_head_pc     = r_ifq[r_ifq_rp];
  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_hold        = r_req_valid & ~iresp_addr_ok;
  assign w_pop         = (r_count != '0) & out_ready;

`ifdef FETCHQ_BYPASS_EN
  assign w_byp     = w_resp & (r_count == '0) & (r_discard == '0) & ~redirect_valid;
  assign out_valid = (r_count != '0) | w_byp;
  assign out_instr = (r_count != '0) ? r_fifo_data[r_rptr] : (w_byp ? iresp_data : 32'h0);
  assign out_pc    = (r_count != '0) ? r_fifo_pc[r_rptr] : (w_byp ? w_head_pc : 32'h0);
`else
  assign w_byp     = 1'b0;
  assign out_valid = (r_count != '0);
  assign out_instr = out_valid ? r_fifo_data[r_rptr] : 32'h0;
  assign out_pc    = out_valid ? r_fifo_pc[r_rptr] : 32'h0;
`endif

  assign w_push     = w_resp & ~w_drop & ~(w_byp & out_ready);
  assign ireq_valid = r_req_valid;
  assign ireq_addr  = r_req_addr;
  assign occupancy  = r_count;

  always_comb begin
    w_inflight_next = r_inflight + IW'(w_accept) - IW'(w_resp);
    w_count_next    = redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
    // A stale held request joins the discard budget only when the bus finally accepts it.
    if (redirect_valid)
      w_discard_next = w_inflight_next;
    else
      w_discard_next = r_discard - IW'(w_resp & (r_discard != '0)) + IW'(w_accept & r_stale);
    if (redirect_valid)
      w_pc_next = w_redirect_pc;
    else if (w_accept & ~r_stale)
      w_pc_next = r_pc + 32'd4;
    else
      w_pc_next = r_pc;
    w_credit = (int'(w_inflight_next) < MAX_OUT) &&
               (int'(w_inflight_next) + int'(w_count_next) < DEPTH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'h0;
      r_stale     <= 1'b0;
      r_inflight  <= '0;
      r_discard   <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ifq_wp    <= '0;
      r_ifq_rp    <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_inflight <= w_inflight_next;
      r_discard  <= w_discard_next;
      r_count    <= w_count_next;
      if (w_hold) begin
        r_stale <= r_stale | redirect_valid;
      end else begin
        r_req_valid <= w_credit;
        r_req_addr  <= w_pc_next;
        r_stale     <= 1'b0;
      end
      if (w_accept) r_ifq_wp <= ifq_inc(r_ifq_wp);
      if (w_resp)   r_ifq_rp <= ifq_inc(r_ifq_rp);
      if (redirect_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_ifq[r_ifq_wp] <= r_req_addr;
    if (w_push) begin
      r_fifo_data[r_wptr] <= iresp_data;
      r_fifo_pc[r_wptr]   <= w_head_pc;
    end
  end

  // A response with nothing outstanding is a bus protocol violation; the logic above ignores it.
  assert property (@(posedge clk) disable iff (!resetn) !(iresp_data_ok && (r_inflight == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a bus model answers accepted requests in order, expected
// request addresses and delivered {pc,instr} pairs are queued per scenario and checked on handshake.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hbfc0_0000)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt;
  int max_occ;
  logic cyc_data_ok;
  logic cyc_out_valid;
  logic m_addr_ok, m_data_en, m_ready;
  logic [31:0] bus_q[$];
  logic [31:0] exp_acc[$];
  logic [31:0] exp_out[$];
  localparam logic [31:0] A0 = 32'hbfc0_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One bus/decode cycle, entered and left on the falling edge.
  task automatic step();
    logic [31:0] e;
    iresp_addr_ok = m_addr_ok;
    out_ready     = m_ready;
    if (m_data_en && bus_q.size() > 0) begin
      iresp_data_ok = 1'b1;
      iresp_data    = mem_word(bus_q[0]);
    end else begin
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
    end
    #1;
    cyc_data_ok   = iresp_data_ok;
    cyc_out_valid = out_valid;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    if (out_valid && out_ready) begin
      n_checks++;
      if (exp_out.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got pc=%h instr=%h, expected no delivery", out_pc, out_instr);
      end else begin
        e = exp_out.pop_front();
        $display("out  pc=%h instr=%h", out_pc, out_instr);
        if (out_pc !== e || out_instr !== mem_word(e)) begin
          n_fail++;
          $display("FAIL out_word: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, e, mem_word(e));
        end
      end
    end
    if (iresp_data_ok) void'(bus_q.pop_front());
    if (ireq_valid && iresp_addr_ok) begin
      acc_cnt++;
      $display("req  addr=%h", ireq_addr);
      if (exp_acc.size() > 0) begin
        e = exp_acc.pop_front();
        n_checks++;
        if (ireq_addr !== e) begin
          n_fail++;
          $display("FAIL req_addr: got %h, expected %h", ireq_addr, e);
        end
      end
      bus_q.push_back(ireq_addr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    bus_q.delete(); exp_acc.delete(); exp_out.delete();
    acc_cnt = 0; max_occ = 0;
    m_addr_ok = 1; m_data_en = 1; m_ready = 1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n, input bit to_out, input bit to_acc);
    for (int i = 0; i < n; i++) begin
      if (to_out) exp_out.push_back(base + 32'(4 * i));
      if (to_acc) exp_acc.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 1;
    #1;
    n_checks++;
    if ({ireq_valid, out_valid, occupancy, out_instr, out_pc} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b out_valid=%b occ=%0d instr=%h pc=%h, expected all 0",
               ireq_valid, out_valid, occupancy, out_instr, out_pc);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_valid: got %b, expected 0", ireq_valid);
    end
    @(negedge clk);
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== A0) begin
      n_fail++;
      $display("FAIL first_request: got valid=%b addr=%h, expected 1 %h", ireq_valid, ireq_addr, A0);
    end
    $display("reset checked");
  endtask

  task automatic test_stream();
    int k;
    do_reset();
    push_seq(A0, 8, 1, 1);
    step();
    step();
    n_checks++;
`ifdef FETCHQ_BYPASS_EN
    if (!(cyc_data_ok && cyc_out_valid)) begin
`else
    if (!(cyc_data_ok && !cyc_out_valid)) begin
`endif
      n_fail++;
      $display("FAIL resp_latency: got data_ok=%b out_valid=%b in first response cycle", cyc_data_ok, cyc_out_valid);
    end
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  task automatic test_full();
    int k;
    do_reset();
    push_seq(A0, 6, 1, 1);
    m_ready = 0;
    repeat (10) step();
    n_checks++;
    if (acc_cnt != 4 || occupancy !== 3'd4 || ireq_valid !== 1'b0 || max_occ != 4) begin
      n_fail++;
      $display("FAIL full_stall: got accepts=%0d occ=%0d valid=%b max_occ=%0d, expected 4 4 0 4",
               acc_cnt, occupancy, ireq_valid, max_occ);
    end
    m_ready = 1;
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  task automatic test_redirect_inflight();
    int k;
    do_reset();
    exp_acc.push_back(A0);
    exp_acc.push_back(A0 + 4);
    push_seq(32'h8000_0010, 3, 1, 1);
    m_data_en = 0;
    step();
    step();
    n_checks++;
    if (ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL max_out_limit: got valid=%b with 2 in flight, expected 0", ireq_valid);
    end
    redirect_valid = 1; redirect_pc = 32'h8000_0013;
    step();
    redirect_valid = 0;
    m_data_en = 1;
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  task automatic test_redirect_held();
    int k;
    do_reset();
    exp_acc.push_back(A0);
    push_seq(32'h9000_0000, 2, 1, 1);
    m_addr_ok = 0;
    step();
    redirect_valid = 1; redirect_pc = 32'h9000_0000;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== A0) begin
        n_fail++;
        $display("FAIL held_request: got valid=%b addr=%h, expected 1 %h", ireq_valid, ireq_addr, A0);
      end
      step();
    end
    m_addr_ok = 1;
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL held_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  task automatic test_redirect_handshake();
    int k;
    do_reset();
    push_seq(A0, 3, 0, 1);
    exp_out.push_back(A0);
    push_seq(32'ha000_0000, 2, 1, 1);
    m_ready = 0;
    step();
    step();
    m_ready = 1;
    redirect_valid = 1; redirect_pc = 32'ha000_0000;
    step();
    redirect_valid = 0;
    n_checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || exp_out.size() != 2) begin
      n_fail++;
      $display("FAIL redirect_handshake: got occ=%0d out_valid=%b pending=%0d, expected 0 0 2",
               occupancy, out_valid, exp_out.size());
    end
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL handshake_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    push_seq(A0, 12, 1, 1);
    repeat (6) step();
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({ireq_valid, out_valid, occupancy, out_instr, out_pc} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got valid=%b out_valid=%b occ=%0d instr=%h pc=%h, expected all 0",
               ireq_valid, out_valid, occupancy, out_instr, out_pc);
    end
    bus_q.delete(); exp_acc.delete(); exp_out.delete();
    iresp_addr_ok = 0; iresp_data_ok = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    push_seq(A0, 4, 1, 1);
    k = 0;
    while (exp_out.size() > 0 && k < 60) begin step(); k++; end
    n_checks++;
    if (exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_timeout: got %0d words missing, expected 0", exp_out.size());
    end
  endtask

  initial begin
    resetn = 1'b0;
    iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    m_addr_ok = 1; m_data_en = 1; m_ready = 1;
    acc_cnt = 0; max_occ = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_redirect_held();
    test_redirect_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
